// File: rtl/range_pkg.sv
// Shared types and defaults for the range-finder session arbiter.
package range_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        REPORT
    } range_arb_state_t;

    localparam int unsigned MAX_LEN_DEF = 255;

endpackage

// File: rtl/range_arbiter_if.sv
// Requester, datapath and result bundle of the range arbiter.
interface range_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       grant;
    logic [WIDTH-1:0]      rf_data_in;
    logic                  rf_go;
    logic                  rf_finish;
    logic [WIDTH-1:0]      rf_range;
    logic                  rf_error;
    logic [WIDTH-1:0]      result;
    logic                  result_valid;
    logic [IW-1:0]         result_id;
    logic                  result_err;
    logic                  busy;

    modport master (
        input  req, req_data, req_last, rf_range, rf_error,
        output grant, rf_data_in, rf_go, rf_finish,
        output result, result_valid, result_id, result_err, busy
    );

    modport slave (
        output req, req_data, req_last, rf_range, rf_error,
        input  grant, rf_data_in, rf_go, rf_finish,
        input  result, result_valid, result_id, result_err, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after rr_ptr, cyclic.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant
);

    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] gdbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   rot_g;

    // Rotate so rr_ptr sits at bit 0, take lowest set bit, rotate back.
    always_comb begin
        dbl   = {req, req} >> rr_ptr;
        rot   = dbl[NREQ-1:0];
        rot_g = rot & (~rot + 1'b1);
        gdbl  = {rot_g, rot_g} << rr_ptr;
        grant = gdbl[2*NREQ-1:NREQ];
    end

endmodule

// File: rtl/range_arbiter.sv
// Shares one range-finder datapath among NREQ requesters, one session at a time.
module range_arbiter
    import range_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic            clock,
    input  logic            reset_n,
    range_arbiter_if.master bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_LEN + 1);

    range_arb_state_t state_q, state_d;

    logic [NREQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    rid_q, rid_d;
    logic             rerr_q, rerr_d;

    logic [NREQ-1:0]  rr_grant;
    logic [IW-1:0]    own;
    logic [WIDTH-1:0] sel_data;
    logic             sel_req;
    logic             sel_last;

    logic             go;
    logic             fin;
    logic             rvalid;
    logic             abort;
    logic             tmo;
    logic [WIDTH-1:0] dout;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (IW)
    ) u_rr (
        .req    (bus.req),
        .rr_ptr (ptr_q),
        .grant  (rr_grant)
    );

    always_comb begin
        own      = '0;
        sel_data = '0;
        sel_req  = 1'b0;
        sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                own      = IW'(i);
                sel_data = bus.req_data[i*WIDTH +: WIDTH];
                sel_req  = bus.req[i];
                sel_last = bus.req_last[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        result_d = result_q;
        rid_d    = rid_q;
        rerr_d   = rerr_q;
        go       = 1'b0;
        fin      = 1'b0;
        rvalid   = 1'b0;
        abort    = 1'b0;
        tmo      = 1'b0;
        dout     = '0;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_d = rr_grant;
                    cnt_d   = CW'(1);
                    err_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                // req_last is deliberately ignored here.
                go      = 1'b1;
                dout    = sel_data;
                err_d   = bus.rf_error;
                cnt_d   = cnt_q + CW'(1);
                state_d = STREAM;
            end
            STREAM: begin
                dout  = sel_data;
                cnt_d = cnt_q + CW'(1);
                err_d = err_q | bus.rf_error;
                abort = ~sel_req;
                tmo   = (cnt_q == CW'(MAX_LEN));
                if (sel_last || abort || tmo) begin
                    fin      = 1'b1;
                    result_d = bus.rf_range;
                    rid_d    = own;
                    rerr_d   = abort | tmo | err_q | bus.rf_error;
                    state_d  = REPORT;
                end
            end
            REPORT: begin
                rvalid  = 1'b1;
                grant_d = '0;
                if (own == IW'(NREQ - 1)) ptr_d = '0;
                else ptr_d = own + IW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            rid_q    <= '0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            result_q <= result_d;
            rid_q    <= rid_d;
            rerr_q   <= rerr_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.rf_data_in   = dout;
    assign bus.rf_go        = go;
    assign bus.rf_finish    = fin;
    assign bus.result       = result_q;
    assign bus.result_valid = rvalid;
    assign bus.result_id    = rid_q;
    assign bus.result_err   = rerr_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_range_arbiter.sv
// Directed and random sessions against a sample-list reference model.
module tb_range_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [N-1:0]   req_v;
    logic [N-1:0]   last_v;
    logic [N*W-1:0] data_v;
    logic           rf_err;

    int       nassert = 0;
    int       nfail = 0;
    bit       sel = 1'b0;
    int       ptr_m = 0;
    logic [W-1:0] res_m = '0;
    logic [W-1:0] smp[$];

    range_arbiter_if #(.WIDTH(W), .NREQ(N)) b0 ();
    range_arbiter_if #(.WIDTH(W), .NREQ(N)) b1 ();

    range_arbiter #(.WIDTH(W), .NREQ(N)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (b0)
    );

    range_arbiter #(.WIDTH(W), .NREQ(N), .MAX_LEN(4)) u_dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (b1)
    );

    assign b0.req      = req_v;
    assign b0.req_data = data_v;
    assign b0.req_last = last_v;
    assign b0.rf_error = rf_err;
    assign b1.req      = req_v;
    assign b1.req_data = data_v;
    assign b1.req_last = last_v;
    assign b1.rf_error = rf_err;

    function automatic logic [W-1:0] fmax(logic [W-1:0] a, logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [W-1:0] fmin(logic [W-1:0] a, logic [W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Behavioural range finder, one per arbiter instance.
    logic [W-1:0] mx0, mn0, mx1, mn1;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mx0 <= '0; mn0 <= '0; mx1 <= '0; mn1 <= '0;
        end else begin
            if (b0.rf_go) begin
                mx0 <= b0.rf_data_in; mn0 <= b0.rf_data_in;
            end else if (b0.busy) begin
                mx0 <= fmax(mx0, b0.rf_data_in); mn0 <= fmin(mn0, b0.rf_data_in);
            end
            if (b1.rf_go) begin
                mx1 <= b1.rf_data_in; mn1 <= b1.rf_data_in;
            end else if (b1.busy) begin
                mx1 <= fmax(mx1, b1.rf_data_in); mn1 <= fmin(mn1, b1.rf_data_in);
            end
        end
    end
    assign b0.rf_range = b0.rf_go ? '0 : fmax(mx0, b0.rf_data_in) - fmin(mn0, b0.rf_data_in);
    assign b1.rf_range = b1.rf_go ? '0 : fmax(mx1, b1.rf_data_in) - fmin(mn1, b1.rf_data_in);

    logic [N-1:0] o_grant;
    logic [W-1:0] o_data, o_result;
    logic [1:0]   o_id;
    logic o_go, o_fin, o_valid, o_err, o_busy;
    assign o_grant  = sel ? b1.grant : b0.grant;
    assign o_data   = sel ? b1.rf_data_in : b0.rf_data_in;
    assign o_result = sel ? b1.result : b0.result;
    assign o_id     = sel ? b1.result_id : b0.result_id;
    assign o_go     = sel ? b1.rf_go : b0.rf_go;
    assign o_fin    = sel ? b1.rf_finish : b0.rf_finish;
    assign o_valid  = sel ? b1.result_valid : b0.result_valid;
    assign o_err    = sel ? b1.result_err : b0.result_err;
    assign o_busy   = sel ? b1.busy : b0.busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, 32'(o_grant), 0);
        chk({tag, "_go"}, 32'(o_go), 0);
        chk({tag, "_fin"}, 32'(o_fin), 0);
        chk({tag, "_valid"}, 32'(o_valid), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_result"}, 32'(o_result), 0);
        chk({tag, "_id"}, 32'(o_id), 0);
        chk({tag, "_err"}, 32'(o_err), 0);
        chk({tag, "_data"}, 32'(o_data), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_v = '0; last_v = '0; rf_err = 1'b0;
        data_v = {$urandom, $urandom};
        #1;
        chk_zero("rst");
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        ptr_m = 0;
        res_m = '0;
    endtask

    function automatic int exp_owner(logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(ptr_m + i) % N]) return (ptr_m + i) % N;
        end
        return -1;
    endfunction

    // mode 0: last on final sample; 1: owner drops req on final sample; 2: no end marker.
    task automatic session(input logic [N-1:0] reqv, input int mode, input bit early,
                           input int err_at, input int maxl, input bit hold);
        int own, fin;
        bit ab_f, to_f, is_last, is_ab, to, ef;
        logic [N-1:0] om;
        logic [W-1:0] mx, mn;
        own = exp_owner(reqv);
        om = N'(1) << own;
        req_v = reqv; last_v = '0; rf_err = 1'b0;
        data_v = {$urandom, $urandom};
        #1;
        chk("idle_busy", 32'(o_busy), 0);
        chk("idle_grant", 32'(o_grant), 0);
        chk("idle_data", 32'(o_data), 0);
        chk("idle_valid", 32'(o_valid), 0);
        chk("idle_hold_result", 32'(o_result), 32'(res_m));
        cyc();
        req_v = (N'($urandom) & ~om) | om;
        data_v = {$urandom, $urandom};
        data_v[own*W +: W] = smp[0];
        last_v = (N'($urandom) & ~om) | (early ? om : '0);
        rf_err = (err_at == 0);
        #1;
        chk("start_grant", 32'(o_grant), 32'(om));
        chk("start_go", 32'(o_go), 1);
        chk("start_fin", 32'(o_fin), 0);
        chk("start_data", 32'(o_data), 32'(smp[0]));
        chk("start_busy", 32'(o_busy), 1);
        cyc();
        fin = -1; ab_f = 0; to_f = 0;
        for (int k = 1; k < smp.size() && fin < 0; k++) begin
            is_last = (mode == 0) && (k == smp.size() - 1);
            is_ab = (mode == 1) && (k == smp.size() - 1);
            to = (k + 1 == maxl);
            req_v = (N'($urandom) & ~om) | (is_ab ? '0 : om);
            data_v = {$urandom, $urandom};
            data_v[own*W +: W] = smp[k];
            last_v = (N'($urandom) & ~om) | (is_last ? om : '0);
            rf_err = (err_at == k);
            #1;
            chk("stream_go", 32'(o_go), 0);
            chk("stream_fin", 32'(o_fin), 32'(is_last | is_ab | to));
            chk("stream_data", 32'(o_data), 32'(smp[k]));
            chk("stream_grant", 32'(o_grant), 32'(om));
            if (is_last | is_ab | to) begin
                fin = k; ab_f = is_ab; to_f = to;
            end
            cyc();
        end
        mx = smp[0]; mn = smp[0];
        for (int i = 1; i <= fin; i++) begin
            if (smp[i] > mx) mx = smp[i];
            if (smp[i] < mn) mn = smp[i];
        end
        ef = ab_f | to_f | (err_at >= 0 && err_at <= fin);
        res_m = mx - mn;
        req_v = hold ? reqv : '0; last_v = '0; rf_err = 1'b0;
        data_v = {$urandom, $urandom};
        #1;
        chk("report_valid", 32'(o_valid), 1);
        chk("report_result", 32'(o_result), 32'(res_m));
        chk("report_id", 32'(o_id), 32'(own));
        chk("report_err", 32'(o_err), 32'(ef));
        chk("report_data", 32'(o_data), 0);
        chk("report_fin", 32'(o_fin), 0);
        ptr_m = (own + 1) % N;
        cyc();
        smp.delete();
    endtask

    initial begin
        int n;
        req_v = '0; last_v = '0; data_v = '0; rf_err = 1'b0;
        do_reset();

        // Contention: grants rotate 0,1,2,3,0.
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 3; i++) smp.push_back(W'($urandom));
            session(4'b1111, 0, 1'b0, -1, 255, 1'b1);
        end

        smp = '{16'd5, 16'd9, 16'd2, 16'd7};
        session(4'b0010, 0, 1'b0, -1, 255, 1'b0);

        smp = '{16'd10, 16'd30, 16'd20};
        session(4'b0100, 1, 1'b0, -1, 255, 1'b0);

        smp = '{16'd8, 16'd8};
        session(4'b0001, 0, 1'b1, -1, 255, 1'b0);

        smp = '{16'd40, 16'd41, 16'd3};
        session(4'b1000, 0, 1'b0, 1, 255, 1'b0);

        for (int s = 0; s < 12; s++) begin
            n = $urandom_range(2, 8);
            for (int i = 0; i < n; i++) smp.push_back(W'($urandom));
            session(N'($urandom_range(1, 15)), $urandom_range(0, 1),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1,
                    255, 1'($urandom_range(0, 1)));
        end

        // Reset during the third sample of a session.
        req_v = 4'b1000; last_v = '0; data_v = {$urandom, $urandom};
        cyc();
        data_v[3*W +: W] = 16'd11;
        cyc();
        data_v[3*W +: W] = 16'd22;
        cyc();
        data_v[3*W +: W] = 16'd33;
        #1;
        chk("mid_busy", 32'(o_busy), 1);
        reset_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        cyc();
        chk("mid_rst_valid_held", 32'(o_valid), 0);
        reset_n = 1'b1;
        ptr_m = 0;
        res_m = '0;
        smp = '{16'd100, 16'd50, 16'd75, 16'd60};
        session(4'b1000, 0, 1'b0, -1, 255, 1'b0);

        do_reset();
        sel = 1'b1;
        smp = '{16'd1, 16'd2, 16'd3, 16'd4};
        session(4'b0001, 2, 1'b0, -1, 4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule

// File: doc/range_arbiter.md
RANGE_ARBITER -- requirements
Module: range_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 16, sample/range width; NREQ, default 4, number of requesters; MAX_LEN, default 255, maximum samples per session before forced finish.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 req  input  NREQ  per-requester session request; held high for the whole session.
REQ-005 req_data  input  NREQ*WIDTH  per-requester sample; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-006 req_last  input  NREQ  per-requester marker: the current sample is the session's last.
REQ-007 grant  output  NREQ  one-hot; the current session owner.
REQ-008 rf_data_in  output  WIDTH  sample forwarded to the shared range-finder datapath.
REQ-009 rf_go  output  1  session start strobe to the datapath.
REQ-010 rf_finish  output  1  session end strobe to the datapath.
REQ-011 rf_range  input  WIDTH  combinational range from the datapath.
REQ-012 rf_error  input  1  datapath debug_error.
REQ-013 result  output  WIDTH  captured range of the last session.
REQ-014 result_valid  output  1  one-cycle pulse; result, result_id and result_err are valid.
REQ-015 result_id  output  $clog2(NREQ)  index of the requester that owned the session.
REQ-016 result_err  output  1  session aborted, timed out, or datapath error.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, START, STREAM and REPORT.
REQ-019 IDLE: with any req bit high, the arbiter SHALL register a one-hot grant to the first requesting index at or after rr_ptr (cyclic) and go to START on the next edge; otherwise it SHALL stay in IDLE with grant=0.
REQ-020 START: rf_go=1 for exactly one cycle, rf_data_in=granted req_data, sample count=1; next state STREAM.
REQ-021 STREAM: rf_data_in SHALL equal the granted req_data each cycle; rf_go=0; count increments each cycle.
REQ-022 Finish SHALL occur in the first STREAM cycle in which granted req_last=1, granted req=0 (abort), or count==MAX_LEN (timeout); that cycle rf_finish=1 and the sample is forwarded.
REQ-023 In the finish cycle, result<=rf_range, result_id<=grant index, result_err<=(abort|timeout|rf_error); next state REPORT.
REQ-024 req_last asserted in START SHALL be ignored; the minimum session is 2 samples.
REQ-025 rf_error high during START/STREAM SHALL be latched sticky into the pending result_err.
REQ-026 REPORT: result_valid=1 for one cycle; grant<=0; rr_ptr<=(owner+1) mod NREQ; next state IDLE.
REQ-027 Request-to-rf_go latency SHALL be 1 cycle; finish-to-result_valid latency SHALL be 1 cycle; the minimum gap between sessions SHALL be 1 IDLE cycle.
REQ-028 Non-granted requesters SHALL have no effect until the next IDLE arbitration.
REQ-029 rf_go and rf_finish SHALL never be high in the same cycle.
REQ-030 rf_data_in SHALL be 0 outside START/STREAM.
REQ-031 result, result_id and result_err SHALL hold their values until the next REPORT.

Reset
REQ-032 reset_n low SHALL immediately force: state=IDLE; grant, rf_go, rf_finish, result_valid and busy =0; result, result_id, result_err and rr_ptr =0; count=0.
REQ-033 Reset mid-session SHALL discard the session with no result_valid pulse; the datapath SHALL share reset_n (inverted) so that it is cleared together with the arbiter.

Structure
REQ-034 The FSM state enum (range_arb_state_t) and the default MAX_LEN constant SHALL live in the shared package range_pkg.
REQ-035 The round-robin selection SHALL be one sub-module, rr_arbiter (inputs: req and rr_ptr; output: one-hot grant); the datapath SHALL stay external.

Verification
REQ-036 Single session: req[1] streams 5, 9, 2, 7 with last on 7 -> rf_go one cycle, rf_finish on 7, result=7, result_id=1, result_err=0.
REQ-037 Contention: req=4'b1111 held, each session 3 samples -> grants 0, 1, 2, 3, 0 in order, with one IDLE cycle between sessions.
REQ-038 Abort: req[2] drops after 2 samples (10, 30) -> rf_finish in the drop cycle, result_err=1, result_id=2.
REQ-039 Timeout: MAX_LEN=4, req[0] never asserts last, samples 1..4 -> forced finish on the 4th sample, result=3, result_err=1.
REQ-040 Reset mid-STREAM: reset_n low during sample 3 -> all outputs 0 immediately, no result_valid; after release a new req[3] session runs normally.
REQ-041 Early last: req_last high in START with samples 8, 8 -> session continues to the next last; result=0, result_err=0.
